// File: rtl/p2p_egress_wrr_sched.sv
// p2p_egress_wrr_sched: packet-atomic weighted round-robin scheduler that
// shares one p2p_tx channel between NUM_Q FWFT egress FIFOs. One arbitration
// cycle per packet; the beat path from the granted FIFO is combinational.
module p2p_egress_wrr_sched #(
   parameter int unsigned NUM_Q        = 4,
   parameter int unsigned C_DATA_WIDTH = 256,
   parameter int unsigned HEAD_WIDTH   = 64,
   parameter int unsigned WEIGHT_W     = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_Q*WEIGHT_W-1:0]       iv_weight,
   input  logic [NUM_Q-1:0]                iv_q_valid,
   input  logic [NUM_Q-1:0]                iv_q_last,
   input  logic [NUM_Q*C_DATA_WIDTH-1:0]   iv_q_data,
   input  logic [NUM_Q*HEAD_WIDTH-1:0]     iv_q_head,
   output logic [NUM_Q-1:0]                ov_q_rd_en,
   output logic                            p2p_tx_valid,
   output logic                            p2p_tx_last,
   output logic [C_DATA_WIDTH-1:0]         p2p_tx_data,
   output logic [HEAD_WIDTH-1:0]           p2p_tx_head,
   input  logic                            p2p_tx_ready,
   output logic [$clog2(NUM_Q)-1:0]        ov_grant,
   output logic                            o_busy
);

   localparam int unsigned GW = $clog2(NUM_Q);

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   state_t                r_state;
   logic [GW-1:0]         r_grant;
   logic [GW-1:0]         r_rr_ptr;
   logic [WEIGHT_W-1:0]   r_credit;

   logic [WEIGHT_W-1:0]   w_weight [NUM_Q];
   logic                  w_found;
   logic [GW-1:0]         w_winner;
   logic [GW-1:0]         w_idx;
   logic [WEIGHT_W-1:0]   w_load_credit;
   logic                  w_regrant;
   logic                  w_accept_last;

   // Split the flat weight bus into one weight per queue
   always_comb begin
      for (int unsigned q = 0; q < NUM_Q; q++) begin
         w_weight[q] = iv_weight[q*WEIGHT_W +: WEIGHT_W];
      end
   end

   // Round-robin search starting just after the last new pick
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int unsigned k = 1; k <= NUM_Q; k++) begin
         w_idx = GW'((32'(r_rr_ptr) + k) % NUM_Q);
         if (!w_found && iv_q_valid[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   // Credit to load on a new pick; weight 0 behaves as 1
   always_comb begin
      w_load_credit = w_weight[w_winner];
      if (w_load_credit == '0) begin
         w_load_credit = WEIGHT_W'(1);
      end
   end

   assign w_regrant = (r_credit != '0) && iv_q_valid[r_grant];

   // Combinational beat mux and pop strobe for the granted queue while in XFER
   always_comb begin
      p2p_tx_valid = 1'b0;
      p2p_tx_last  = 1'b0;
      p2p_tx_data  = '0;
      p2p_tx_head  = '0;
      ov_q_rd_en   = '0;
      if (r_state == XFER) begin
         for (int unsigned q = 0; q < NUM_Q; q++) begin
            if (GW'(q) == r_grant) begin
               p2p_tx_valid  = iv_q_valid[q];
               p2p_tx_last   = iv_q_last[q];
               p2p_tx_data   = iv_q_data[q*C_DATA_WIDTH +: C_DATA_WIDTH];
               p2p_tx_head   = iv_q_head[q*HEAD_WIDTH +: HEAD_WIDTH];
               ov_q_rd_en[q] = iv_q_valid[q] & p2p_tx_ready;
            end
         end
      end
   end

   assign w_accept_last = (r_state == XFER) & p2p_tx_valid & p2p_tx_ready & p2p_tx_last;

   // Arbitration / transfer state machine with grant, pointer and credit registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_grant  <= '0;
         r_rr_ptr <= GW'(NUM_Q - 1);
         r_credit <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_regrant) begin
                  r_state <= XFER;
               end else if (w_found) begin
                  r_grant  <= w_winner;
                  r_rr_ptr <= w_winner;
                  r_credit <= w_load_credit;
                  r_state  <= XFER;
               end else begin
                  r_credit <= '0;
               end
            end
            XFER: begin
               if (w_accept_last) begin
                  // credit saturates at zero so it never wraps
                  if (r_credit != '0) begin
                     r_credit <= r_credit - WEIGHT_W'(1);
                  end
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end

   assign ov_grant = r_grant;
   assign o_busy   = (r_state == XFER);

endmodule

// File: tb/tb_p2p_egress_wrr_sched.sv
// Self-checking bench for p2p_egress_wrr_sched: bench-side FIFOs feed the DUT,
// a packet-level scheduling model predicts every output each cycle, and
// directed scenarios pin grant order, latency, pop counts and stalls.
module tb_p2p_egress_wrr_sched;

   localparam int NQ = 4;
   localparam int DW = 256;
   localparam int HW = 64;
   localparam int WW = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [HW-1:0] head;
      logic          last;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NQ*WW-1:0]  iv_weight = '0;
   logic [NQ-1:0]     iv_q_valid = '0;
   logic [NQ-1:0]     iv_q_last = '0;
   logic [NQ*DW-1:0]  iv_q_data = '0;
   logic [NQ*HW-1:0]  iv_q_head = '0;
   logic [NQ-1:0]     ov_q_rd_en;
   logic              p2p_tx_valid;
   logic              p2p_tx_last;
   logic [DW-1:0]     p2p_tx_data;
   logic [HW-1:0]     p2p_tx_head;
   logic              p2p_tx_ready = 1'b0;
   logic [1:0]        ov_grant;
   logic              o_busy;

   p2p_egress_wrr_sched #(
      .NUM_Q        (NQ),
      .C_DATA_WIDTH (DW),
      .HEAD_WIDTH   (HW),
      .WEIGHT_W     (WW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .iv_weight    (iv_weight),
      .iv_q_valid   (iv_q_valid),
      .iv_q_last    (iv_q_last),
      .iv_q_data    (iv_q_data),
      .iv_q_head    (iv_q_head),
      .ov_q_rd_en   (ov_q_rd_en),
      .p2p_tx_valid (p2p_tx_valid),
      .p2p_tx_last  (p2p_tx_last),
      .p2p_tx_data  (p2p_tx_data),
      .p2p_tx_head  (p2p_tx_head),
      .p2p_tx_ready (p2p_tx_ready),
      .ov_grant     (ov_grant),
      .o_busy       (o_busy)
   );

   always #5 clk = ~clk;

   beat_t   fifo [NQ][$];
   int      n_total = 0;
   int      n_bad   = 0;
   int      cyc     = 0;
   bit      rst_req = 1'b1;
   bit      ready   = 1'b1;
   bit [NQ-1:0] stall = '0;

   // scheduling model: packet in flight, owner, last new pick, packets left in turn
   bit      m_busy  = 1'b0;
   int      m_grant = 0;
   int      m_rr    = NQ - 1;
   int      m_credit = 0;

   int      order_log[$];
   int      acc_cyc[$];
   int      exp_ord[$];
   int      pops[NQ];
   int      first_pop;
   int      busy_gap;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_order(input string nm);
      chk({nm, "_len"}, order_log.size(), exp_ord.size());
      for (int i = 0; i < exp_ord.size(); i++) begin
         if (i < order_log.size()) chk({nm, "_entry"}, order_log[i], exp_ord[i]);
      end
   endtask

   task automatic clear_logs();
      order_log.delete();
      acc_cyc.delete();
      for (int q = 0; q < NQ; q++) pops[q] = 0;
      first_pop = -1;
      busy_gap  = 0;
   endtask

   task automatic push_pkt(input int q, input int nbeats, input int id);
      beat_t b;
      for (int i = 0; i < nbeats; i++) begin
         b.data = {8{q[7:0], id[7:0], 16'(i)}};
         b.head = {32'hC0DE0000 | 32'(q), 32'(id)};
         b.last = (i == nbeats - 1);
         fifo[q].push_back(b);
      end
   endtask

   // One clock: drive at negedge, predict and compare at negedge+1, commit at posedge
   task automatic step();
      bit [NQ-1:0]   vis;
      bit            e_valid, e_last, e_busy;
      logic [DW-1:0] e_data;
      logic [HW-1:0] e_head;
      bit [NQ-1:0]   e_rd;
      int            e_grant;
      bit            n_busy;
      int            n_grant, n_rr, n_credit, w, g;
      bit            found;
      logic [NQ-1:0] s_rd;

      @(negedge clk);
      rst = rst_req;
      p2p_tx_ready = ready;
      for (int q = 0; q < NQ; q++) begin
         vis[q] = (fifo[q].size() > 0) && !stall[q];
         iv_q_valid[q] = vis[q];
         iv_q_last[q]  = vis[q] ? fifo[q][0].last : 1'b0;
         iv_q_data[q*DW +: DW] = vis[q] ? fifo[q][0].data : '0;
         iv_q_head[q*HW +: HW] = vis[q] ? fifo[q][0].head : '0;
      end
      #1;
      e_valid = 0; e_last = 0; e_busy = 0; e_data = '0; e_head = '0; e_rd = '0; e_grant = 0;
      n_busy = m_busy; n_grant = m_grant; n_rr = m_rr; n_credit = m_credit;
      if (rst_req) begin
         n_busy = 0; n_grant = 0; n_rr = NQ - 1; n_credit = 0;
      end else if (!m_busy) begin
         e_grant = m_grant;
         if (m_credit > 0 && vis[m_grant]) begin
            n_busy = 1;
         end else begin
            found = 0;
            for (int k = 1; k <= NQ; k++) begin
               int q;
               q = (m_rr + k) % NQ;
               if (!found && vis[q]) begin
                  found = 1;
                  w = int'(iv_weight[q*WW +: WW]);
                  n_grant = q; n_rr = q; n_credit = (w == 0) ? 1 : w; n_busy = 1;
               end
            end
            if (!found) n_credit = 0;
         end
      end else begin
         g = m_grant;
         e_busy = 1; e_grant = g; e_valid = vis[g];
         if (vis[g]) begin
            e_data = fifo[g][0].data; e_head = fifo[g][0].head; e_last = fifo[g][0].last;
            e_rd[g] = ready;
         end
         if (e_valid && ready && e_last) begin
            if (m_credit > 0) n_credit = m_credit - 1;
            n_busy = 0;
            order_log.push_back(g);
            acc_cyc.push_back(cyc);
         end
      end
      for (int q = 0; q < NQ; q++) begin
         if (e_rd[q]) begin
            if (first_pop < 0) first_pop = cyc;
            pops[q]++;
         end
      end
      if (e_busy && !e_valid) busy_gap++;
      chk("valid", p2p_tx_valid, e_valid);
      chk("last",  p2p_tx_last,  e_last);
      chk("data",  p2p_tx_data,  e_data);
      chk("head",  p2p_tx_head,  e_head);
      chk("rd_en", ov_q_rd_en,   e_rd);
      chk("grant", ov_grant,     e_grant);
      chk("busy",  o_busy,       e_busy);
      s_rd = ov_q_rd_en;
      @(posedge clk);
      if (!rst_req) begin
         for (int q = 0; q < NQ; q++) begin
            if (s_rd[q] && fifo[q].size() > 0) void'(fifo[q].pop_front());
         end
      end
      m_busy = n_busy; m_grant = n_grant; m_rr = n_rr; m_credit = n_credit;
      cyc++;
   endtask

   function automatic bit all_done();
      bit d;
      d = !m_busy;
      for (int q = 0; q < NQ; q++) if (fifo[q].size() > 0) d = 0;
      return d;
   endfunction

   task automatic drain(input int budget, input string nm);
      bit done;
      done = 0;
      for (int i = 0; i < budget; i++) begin
         if (all_done()) begin
            done = 1;
            break;
         end
         step();
      end
      if (!done) done = all_done();
      chk({nm, "_drain_timeout"}, done, 1'b1);
   endtask

   task automatic do_reset();
      rst_req = 1;
      step();
      rst_req = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      bit done;
      bit stalled;

      clear_logs();
      iv_weight = 16'h1111;
      rst_req = 1; ready = 1;
      step(); step();
      rst_req = 0;
      step();

      // 1: single 3-beat packet from q0
      clear_logs();
      t0 = cyc;
      push_pkt(0, 3, 1);
      drain(40, "t1");
      chk("t1_pops_q0", pops[0], 3);
      chk("t1_first_pop_latency", first_pop - t0, 1);
      chk("t1_last_on_third", acc_cyc[0] - first_pop, 2);
      exp_ord = '{0};
      chk_order("t1_order");

      // 2: all weights 1, two 1-beat packets per queue
      do_reset();
      iv_weight = 16'h1111;
      clear_logs();
      for (int p = 0; p < 2; p++) for (int q = 0; q < NQ; q++) push_pkt(q, 1, 20 + p);
      drain(100, "t2");
      exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
      chk_order("t2_order");
      for (int i = 1; i < acc_cyc.size(); i++) chk("t2_pkt_spacing", acc_cyc[i] - acc_cyc[i-1], 2);

      // 2b: all weights 0 behave as weight 1
      do_reset();
      iv_weight = 16'h0000;
      clear_logs();
      for (int p = 0; p < 2; p++) for (int q = 0; q < NQ; q++) push_pkt(q, 1, 30 + p);
      drain(100, "t2b");
      chk_order("t2b_order");

      // 3: q3 weight 3, others 1, backlogged
      do_reset();
      iv_weight = 16'h3111;
      clear_logs();
      for (int p = 0; p < 6; p++) for (int q = 0; q < NQ; q++) if (q == 3 || p < 3) push_pkt(q, 1, 40 + p);
      drain(200, "t3");
      exp_ord = '{0, 1, 2, 3, 3, 3, 0, 1, 2, 3, 3, 3, 0, 1, 2};
      chk_order("t3_order");

      // 4: ready toggling during a 4-beat packet from q1
      iv_weight = 16'h1111;
      clear_logs();
      push_pkt(1, 4, 50);
      done = 0;
      for (int i = 0; i < 60; i++) begin
         if (all_done()) begin
            done = 1;
            break;
         end
         ready = (i % 2 == 0);
         step();
      end
      ready = 1;
      chk("t4_drain_timeout", done, 1'b1);
      chk("t4_pops_q1", pops[1], 4);
      chk("t4_pops_other", pops[0] + pops[2] + pops[3], 0);
      exp_ord = '{1};
      chk_order("t4_order");

      // 5: q2 underrun for 5 cycles mid-packet
      clear_logs();
      push_pkt(2, 4, 60);
      done = 0; stalled = 0;
      for (int i = 0; i < 80; i++) begin
         if (all_done()) begin
            done = 1;
            break;
         end
         if (!stalled && pops[2] == 2) begin
            stall[2] = 1;
            repeat (5) step();
            stall[2] = 0;
            stalled = 1;
         end else begin
            step();
         end
      end
      chk("t5_drain_timeout", done, 1'b1);
      chk("t5_pops_q2", pops[2], 4);
      chk("t5_underrun_cycles", busy_gap, 5);
      exp_ord = '{2};
      chk_order("t5_order");

      // 6: reset on beat 2 of a 4-beat q0 packet, q1 also waiting
      clear_logs();
      push_pkt(0, 4, 70);
      push_pkt(1, 1, 71);
      done = 0;
      for (int i = 0; i < 20; i++) begin
         if (pops[0] == 1) begin
            done = 1;
            break;
         end
         step();
      end
      chk("t6_first_beat_timeout", done, 1'b1);
      rst_req = 1;
      step(); step();
      rst_req = 0;
      chk("t6_no_pop_in_rst", pops[0], 1);
      chk("t6_q0_left", fifo[0].size(), 3);
      clear_logs();
      drain(60, "t6");
      exp_ord = '{0, 1};
      chk_order("t6_order");
      chk("t6_pops_q0_after", pops[0], 3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
